// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter slice.
// Contents: requester count, owner-index width and the arbiter state encoding.
package arb_pkg;

  localparam int NREQ = 8;
  localparam int ID_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/priority_encoder3to8.sv
// Priority encoder: returns the index of the highest set bit of an 8-bit vector.
// Ports:
//   vec_i   - input vector
//   idx_o   - index of the highest set bit (0 when vec_i is zero)
//   valid_o - high when any bit of vec_i is set
module priority_encoder3to8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] vec_i,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  // Ascending scan: the last (highest) set bit overwrites earlier ones.
  always_comb begin
    idx_o   = '0;
    valid_o = |vec_i;
    for (int i = 0; i < NREQ; i++) begin
      if (vec_i[i]) idx_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a hold-time limit.
// A grant is held until the owner drops its request, or until the owner has
// held for MAX_HOLD cycles while another requester is waiting (preemption).
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-high reset
//   req       - request vector, bit i held high by requester i
//   gnt       - registered one-hot grant
//   gnt_id    - binary index of the current owner (0 when no grant)
//   gnt_valid - high while any grant is active
//   preempt   - one-cycle pulse in the cycle after a timeout revocation
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q;
  logic [ID_W-1:0]  last_id_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [NREQ-1:0]  gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic             preempt_q;

  logic [NREQ-1:0]  masked;
  logic [ID_W-1:0]  masked_idx;
  logic             masked_vld;
  logic [ID_W-1:0]  raw_idx;
  logic             raw_vld;
  logic [ID_W-1:0]  winner;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == HOLD_LAST) ? c : c + CNT_W'(1);
  endfunction

  // Only requesters strictly below the last owner are eligible in the masked
  // pass; if none request, the raw pass wraps around to the top. This yields
  // descending round-robin with the last owner at lowest priority.
  assign masked = req & ((NREQ'(1) << last_id_q) - NREQ'(1));

  priority_encoder3to8 u_enc_masked (
    .vec_i   (masked),
    .idx_o   (masked_idx),
    .valid_o (masked_vld)
  );

  priority_encoder3to8 u_enc_raw (
    .vec_i   (req),
    .idx_o   (raw_idx),
    .valid_o (raw_vld)
  );

  assign winner = masked_vld ? masked_idx : raw_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_id_q  <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      preempt_q  <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (raw_vld) begin
            gnt_q      <= NREQ'(1) << winner;
            gnt_id_q   <= winner;
            last_id_q  <= winner;
            hold_cnt_q <= '0;
            state_q    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Release wins over timeout, so a simultaneous drop never pulses preempt.
          if (!req[gnt_id_q]) begin
            gnt_q    <= '0;
            gnt_id_q <= '0;
            state_q  <= ST_IDLE;
          end else if ((hold_cnt_q == HOLD_LAST) && (|(req & ~gnt_q))) begin
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            preempt_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            hold_cnt_q <= sat_inc(hold_cnt_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign preempt   = preempt_q;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Eight-requester round-robin arbiter that shares a single resource among requesters `req[7:0]`.
- Holds one grant until the owner releases it, or until a hold-time limit expires while others are waiting.
- Winner selection reuses the team's existing priority_encoder3to8, where the highest set bit wins.
- Sits in front of any shared datapath unit; its `gnt_id` drives that unit's select mux.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant while other requests are pending. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i held high by requester i while it wants or uses the resource
- gnt  output  8  one-hot grant, registered
- gnt_id  output  3  binary index of current owner; 0 when gnt_valid=0
- gnt_valid  output  1  high while any grant is active (equals OR of gnt)
- preempt  output  1  one-cycle pulse in the cycle after a grant is revoked by timeout

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset: gnt=0, gnt_id=0, gnt_valid=0, preempt=0, state=IDLE, last_id=0, hold_cnt=0.
- Reset mid-operation: the same values apply at the next edge. Any active grant is dropped with no preempt pulse.
- Internal state is IDLE or GRANT. Register last_id[2:0] holds the most recent owner.
- Arbitration (combinational):
  - masked = req & ((1<<last_id)-1), i.e. the bits strictly below last_id.
  - If masked≠0, winner = highest set bit of masked. Otherwise winner = highest set bit of req.
  - Net effect: descending order with wrap-around. The last owner has lowest priority.
  - After reset (last_id=0), the highest-index requester wins.
- IDLE:
  - If req≠0 at edge t: at t+1 gnt=1<<winner, gnt_id=winner, gnt_valid=1, last_id=winner, hold_cnt=0, state=GRANT.
  - Grant latency is therefore one cycle.
  - If req=0, remain in IDLE with all outputs 0.
- GRANT, evaluated in priority order:
  1. Release: req[gnt_id]=0 at edge t → at t+1 gnt=0, gnt_valid=0, state=IDLE.
     - There is always one dead cycle between owners.
     - Release takes priority over timeout when both occur at the same edge; preempt stays 0.
  2. Timeout: hold_cnt==MAX_HOLD-1 and (req & ~gnt)≠0 → at t+1 gnt=0, preempt=1 for exactly one cycle, state=IDLE.
     - If the revoked owner still requests, it re-enters arbitration at lowest priority.
  3. Otherwise hold the grant. hold_cnt increments, saturating at MAX_HOLD-1.
     - An owner with no competitors may hold indefinitely.
     - Timeout fires on the first edge at which a competitor appears while saturated.
- hold_cnt is cleared on every new grant.
- Requests that drop while not granted have no effect.
- preempt is 0 in every cycle except the one following a timeout revocation.
- gnt is always zero or one-hot. gnt_id always matches gnt.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1
  - NREQ=8
  - ID_W=3
- Sub-module: priority_encoder3to8, instantiated twice (masked vector and raw vector). The mux between the two outputs stays in this block.

Test Plan:
- Basic grant/release:
  - Stimulus: reset 2 cycles, then req=8'b00000100.
  - Required: gnt=8'b00000100, gnt_id=2 one cycle later. After req drops, gnt=0 the next cycle.
- Rotation:
  - Stimulus: req=8'b10010010 held constant, each owner drops its bit for one cycle after 3 cycles of grant, then reasserts.
  - Required: grant order is 7,4,1,7, with one idle cycle between owners.
- Timeout with competitor:
  - Stimulus: MAX_HOLD=4; req=8'b01000000, then req=8'b01000001 after 10 cycles.
  - Required: gnt_id=6 is held while alone. Revoked on the first edge with bit 0 present, preempt=1 for one cycle, then gnt_id=0.
- Simultaneous release and timeout:
  - Stimulus: owner drops req in the same cycle hold_cnt reaches MAX_HOLD-1 with others pending.
  - Required: preempt=0; normal release.
- Reset mid-grant:
  - Stimulus: assert reset while gnt=8'b00100000.
  - Required: next edge gives all outputs 0 and last_id=0. After reset release with req=8'b11111111, gnt_id=7.
- Invariant check every cycle:
  - Required: $countones(gnt)≤1, gnt_valid==|gnt, gnt_id consistent with gnt, and no grant to a requester whose req was 0 at the deciding edge.
